axi_txn_scheduler: RTL
======================

Name: axi_txn_scheduler

Overview:
- Transaction-level round-robin scheduler that shares one AXI slave port between NUM_M masters.
- Grant is taken once per complete transaction: write = AW, W burst, B; read = AR, R burst.
- Gates VALID/READY between the granted master and the slave; the external address/data muxes steer on gnt.
- Watchdog timer releases a hung transaction.

Parameters:
NUM_M, 2, number of masters (2..8)
TIMEOUT, 255, idle cycles allowed inside a transaction before forced release (1..2^TO_W-1)
TO_W, 8, watchdog counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
m_awvalid  in  NUM_M  per-master AWVALID
m_arvalid  in  NUM_M  per-master ARVALID
m_wvalid  in  NUM_M  per-master WVALID
m_wlast  in  NUM_M  per-master WLAST
m_bready  in  NUM_M  per-master BREADY
m_rready  in  NUM_M  per-master RREADY
m_awready  out  NUM_M  AWREADY to masters
m_arready  out  NUM_M  ARREADY to masters
m_wready  out  NUM_M  WREADY to masters
m_bvalid  out  NUM_M  BVALID to masters
m_rvalid  out  NUM_M  RVALID to masters
s_awvalid/s_arvalid/s_wvalid/s_wlast/s_bready/s_rready  out  1 each  slave-side gated handshakes
s_awready/s_arready/s_wready/s_bvalid/s_rvalid/s_rlast  in  1 each  slave-side handshakes
gnt  out  NUM_M  one-hot owner; drives external data muxes
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
Reset:
- All outputs 0; state IDLE; priority pointer favours master 0; watchdog counter 0.

Request and arbitration:
- req[i] = m_awvalid[i] | m_arvalid[i].
- Round-robin uses a masked/unmasked pair: masked = req & pointer mask. Lowest-index masked request wins; if the masked set is empty, the lowest-index unmasked request wins.
- IDLE with req != 0: register gnt = winner (one-hot).
  - Next state WADDR if the winner's m_awvalid = 1 (write beats read for the same master), else RADDR.
- Latency: the address phase starts the cycle after the request is seen.

Gating (g = granted index):
- Handshake signals pass through only in their own phase; all other master outputs are 0.
- Inputs from non-granted masters are ignored.

States:
- WADDR: s_awvalid = m_awvalid[g]; m_awready[g] = s_awready. Handshake -> WDATA.
- WDATA: s_wvalid = m_wvalid[g]; s_wlast = m_wlast[g]; m_wready[g] = s_wready. Handshake with wlast = 1 -> WRESP.
- WRESP: m_bvalid[g] = s_bvalid; s_bready = m_bready[g]. Handshake -> IDLE. BRESP value is not inspected.
- RADDR: s_arvalid = m_arvalid[g]; m_arready[g] = s_arready. Handshake -> RDATA.
- RDATA: m_rvalid[g] = s_rvalid; s_rready = m_rready[g]. Handshake with s_rlast = 1 -> IDLE.

Release:
- On return to IDLE (normal or timeout): gnt cleared to 0 and pointer mask set so master g has lowest priority.
- IDLE lasts at least one cycle between transactions; no back-to-back grant in the completion cycle.
- Requests dropping mid-transaction do not change gnt.

Watchdog:
- Counter clears on entry to a non-IDLE state and on every handshake.
- Otherwise it increments in non-IDLE states.
- Count == TIMEOUT: go to IDLE, pulse timeout_err for 1 cycle, release the grant as above.
- A handshake in the same cycle as the timeout wins: the counter clears and no timeout occurs.

Reset mid-transaction:
- Immediate return to IDLE with all outputs 0; the slave protocol state is the system's responsibility.

Test Plan:
- Single write, NUM_M=2: M1 awvalid, slave ready=1, 2-beat W, bvalid -> gnt=2'b10 one cycle after request; states WADDR, WDATA×2, WRESP, IDLE; m_*ready[0] stays 0 throughout.
- Fairness: both masters issue continuous reads, 1-beat R -> grants alternate 01, 10, 01, 10; IDLE appears between transactions.
- Same-master priority: M0 awvalid=1 and arvalid=1 together -> WADDR chosen; the read is served after the write completes (M1 idle).
- Stall hold: M0 read in RDATA, slave holds rvalid=0 for 100 cycles with TIMEOUT=255 -> gnt stays 01, no timeout_err; completes normally on rlast.
- Watchdog: slave never asserts bvalid -> exactly TIMEOUT cycles after WRESP entry, timeout_err=1 for one cycle; gnt=0 and busy=0 the next cycle; next grant goes to M1 when both request.
- Async reset asserted in WDATA -> all outputs 0 immediately; after release, the first grant goes to M0 when both request.

Source files
------------

// File: rtl/axi_txn_scheduler.sv
// axi_txn_scheduler
//   Shares one AXI slave port between NUM_M masters, granting ownership for a
//   whole transaction (AW/W/B or AR/R) in round-robin order. VALID/READY are
//   gated to the granted master only; external address/data muxes steer on gnt.
//   A watchdog releases a transaction that sits idle for TIMEOUT cycles.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among requesting masters
//   WADDR | write address handshake for owner
//   WDATA | write data burst until WLAST beat
//   WRESP | write response handshake
//   RADDR | read address handshake for owner
//   RDATA | read data burst until RLAST beat
//
// Ports:
//   clk, rst (async, active-low)
//   m_*        per-master handshakes (NUM_M bits each)
//   s_*        slave-side handshakes (1 bit each)
//   gnt        one-hot owner, busy = not IDLE, timeout_err = watchdog pulse
module axi_txn_scheduler #(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] m_awvalid,
  input  logic [NUM_M-1:0] m_arvalid,
  input  logic [NUM_M-1:0] m_wvalid,
  input  logic [NUM_M-1:0] m_wlast,
  input  logic [NUM_M-1:0] m_bready,
  input  logic [NUM_M-1:0] m_rready,
  output logic [NUM_M-1:0] m_awready,
  output logic [NUM_M-1:0] m_arready,
  output logic [NUM_M-1:0] m_wready,
  output logic [NUM_M-1:0] m_bvalid,
  output logic [NUM_M-1:0] m_rvalid,
  output logic             s_awvalid,
  output logic             s_arvalid,
  output logic             s_wvalid,
  output logic             s_wlast,
  output logic             s_bready,
  output logic             s_rready,
  input  logic             s_awready,
  input  logic             s_arready,
  input  logic             s_wready,
  input  logic             s_bvalid,
  input  logic             s_rvalid,
  input  logic             s_rlast,
  output logic [NUM_M-1:0] gnt,
  output logic             busy,
  output logic             timeout_err
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    win;
  logic [NUM_M-1:0] mask;
  logic [NUM_M-1:0] mask_rel;
  logic [NUM_M-1:0] req;
  logic [TO_W-1:0]  cnt;
  logic             hs;
  logic             to_hit;

  assign req  = m_awvalid | m_arvalid;
  assign busy = (state != IDLE);

  // Lowest-index request wins, unless a masked (higher-priority) request
  // exists, in which case the lowest masked one wins.
  always_comb begin
    win = '0;
    for (int i = NUM_M - 1; i >= 0; i--)
      if (req[i]) win = IW'(i);
    for (int i = NUM_M - 1; i >= 0; i--)
      if (req[i] && mask[i]) win = IW'(i);
  end

  // Mask after releasing gidx: only masters above it stay in the favoured set.
  always_comb begin
    mask_rel = '0;
    for (int i = 0; i < NUM_M; i++)
      mask_rel[i] = (IW'(i) > gidx);
  end

  always_comb begin
    state_nxt   = state;
    hs          = 1'b0;
    m_awready   = '0;
    m_arready   = '0;
    m_wready    = '0;
    m_bvalid    = '0;
    m_rvalid    = '0;
    s_awvalid   = 1'b0;
    s_arvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_wlast     = 1'b0;
    s_bready    = 1'b0;
    s_rready    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) state_nxt = m_awvalid[win] ? WADDR : RADDR;
      end
      WADDR: begin
        s_awvalid       = m_awvalid[gidx];
        m_awready[gidx] = s_awready;
        hs              = m_awvalid[gidx] & s_awready;
        if (hs) state_nxt = WDATA;
      end
      WDATA: begin
        s_wvalid       = m_wvalid[gidx];
        s_wlast        = m_wlast[gidx];
        m_wready[gidx] = s_wready;
        hs             = m_wvalid[gidx] & s_wready;
        if (hs && m_wlast[gidx]) state_nxt = WRESP;
      end
      WRESP: begin
        m_bvalid[gidx] = s_bvalid;
        s_bready       = m_bready[gidx];
        hs             = s_bvalid & m_bready[gidx];
        if (hs) state_nxt = IDLE;
      end
      RADDR: begin
        s_arvalid       = m_arvalid[gidx];
        m_arready[gidx] = s_arready;
        hs              = m_arvalid[gidx] & s_arready;
        if (hs) state_nxt = RDATA;
      end
      RDATA: begin
        m_rvalid[gidx] = s_rvalid;
        s_rready       = m_rready[gidx];
        hs             = s_rvalid & m_rready[gidx];
        if (hs && s_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A handshake in the expiry cycle counts as progress, so it wins.
    to_hit = (state != IDLE) && !hs && (cnt == TO_W'(TIMEOUT));
    if (to_hit) state_nxt = IDLE;
  end

  assign timeout_err = to_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      mask  <= '1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (|req) begin
          gnt  <= NUM_M'(1) << win;
          gidx <= win;
        end
      end else if (state_nxt == IDLE) begin
        gnt  <= '0;
        mask <= mask_rel;
      end
      if (state == IDLE || hs || to_hit) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
    end
  end

endmodule
